// File: rtl/hashgen_pkg.sv
// hashgen_pkg: shared types and config legality check for the candidate generator.
package hashgen_pkg;
  localparam int CHAR_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic cfg_bad(int nc, int len, int lo, int hi, int max_len, int max_chars);
    return nc == 0 || len == 0 || len > max_len || nc > max_chars || lo > hi || hi >= nc;
  endfunction
endpackage

// File: rtl/candidate_digit.sv
// candidate_digit: one odometer position; wraps hi -> lo and carries out on wrap.
module candidate_digit #(
  parameter int IW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [IW-1:0] load_val,
  input  logic          act,
  input  logic          carry_in,
  input  logic [IW-1:0] lo,
  input  logic [IW-1:0] hi,
  output logic [IW-1:0] idx_nxt,
  output logic          carry_out
);
  logic [IW-1:0] idx_q, idx_d;
  logic wrap;
  always_comb begin
    wrap = idx_q == hi;
    carry_out = act && carry_in && wrap;
    idx_d = load ? load_val : (act && carry_in) ? (wrap ? lo : idx_q + IW'(1)) : idx_q;
    idx_nxt = idx_d;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) idx_q <= '0;
    else idx_q <= idx_d;
endmodule

// File: rtl/candidate_generator.sv
// candidate_generator: odometer over a programmable charset, one candidate per handshake,
// with fixed or growing length and a first-character partition range.
module candidate_generator
  import hashgen_pkg::*;
#(
  parameter int MAX_LEN   = 8,
  parameter int MAX_CHARS = 96,
  parameter int CNT_W     = 48
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cs_we,
  input  logic [$clog2(MAX_CHARS)-1:0]   cs_addr,
  input  logic [7:0]                     cs_data,
  input  logic [$clog2(MAX_CHARS+1)-1:0] cfg_numchars,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  input  logic                           cfg_grow,
  input  logic [$clog2(MAX_CHARS)-1:0]   cfg_first_lo,
  input  logic [$clog2(MAX_CHARS)-1:0]   cfg_first_hi,
  input  logic                           start,
  input  logic                           abort,
  output logic                           cand_valid,
  input  logic                           cand_ready,
  output logic [8*MAX_LEN-1:0]           cand_data,
  output logic [$clog2(MAX_LEN+1)-1:0]   cand_len,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic [CNT_W-1:0]               cand_cnt
);
  localparam int IW = $clog2(MAX_CHARS);
  localparam int NW = $clog2(MAX_CHARS+1);
  localparam int LW = $clog2(MAX_LEN+1);
  state_t state_q, state_d;
  logic [NW-1:0] num_q, num_d;
  logic [LW-1:0] len_q, len_d, tgt_q, tgt_d;
  logic grow_q, grow_d, valid_q, valid_d, done_q, done_d, err_q, err_d;
  logic [IW-1:0] lo_q, lo_d, hi_q, hi_d, nm1, lo_v;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8*MAX_LEN-1:0] data_q, data_d;
  logic [CHAR_W-1:0] cs_q [MAX_CHARS];
  logic [IW-1:0] nxt [MAX_LEN];
  logic carry [MAX_LEN+1];
  logic cin [MAX_LEN];
  logic bad, go, hs, last_len, load, upd;
  assign bad = cfg_bad(int'(cfg_numchars), int'(cfg_len), int'(cfg_first_lo), int'(cfg_first_hi),
                       MAX_LEN, MAX_CHARS);
  assign go = start && !abort && state_q != RUN;
  assign hs = state_q == RUN && valid_q && cand_ready;
  assign last_len = !(grow_q && len_q < tgt_q);
  assign load = (go && !bad) || (!abort && hs && carry[0] && !last_len);
  assign upd = load || hs;
  assign nm1 = IW'(num_q - NW'(1));
  assign lo_v = go ? cfg_first_lo : lo_q;
  assign carry[MAX_LEN] = 1'b0;
  // Position cur_len-1 is the fastest digit; carries ripple toward position 0.
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_dig
    assign cin[i] = (int'(len_q) == i + 1) ? hs : carry[i+1];
    candidate_digit #(.IW(IW)) u_dig (
      .clk(clk), .rst(rst), .load(load),
      .load_val(i == 0 ? lo_v : '0),
      .act(i < int'(len_q)),
      .carry_in(cin[i]),
      .lo(i == 0 ? lo_q : '0),
      .hi(i == 0 ? hi_q : nm1),
      .idx_nxt(nxt[i]),
      .carry_out(carry[i])
    );
  end
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    done_d = done_q;
    err_d = err_q;
    len_d = len_q;
    num_d = num_q;
    tgt_d = tgt_q;
    grow_d = grow_q;
    lo_d = lo_q;
    hi_d = hi_q;
    cnt_d = (hs && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    if (abort) begin
      state_d = IDLE;
      valid_d = 1'b0;
      done_d = 1'b0;
    end else if (go) begin
      num_d = cfg_numchars;
      tgt_d = cfg_len;
      grow_d = cfg_grow;
      lo_d = cfg_first_lo;
      hi_d = cfg_first_hi;
      cnt_d = '0;
      state_d = bad ? DONE : RUN;
      valid_d = !bad;
      done_d = bad;
      err_d = bad;
      len_d = bad ? len_q : (cfg_grow ? LW'(1) : cfg_len);
    end else if (hs && carry[0]) begin
      state_d = last_len ? DONE : RUN;
      valid_d = !last_len;
      done_d = last_len;
      len_d = last_len ? len_q : len_q + LW'(1);
    end
    for (int i = 0; i < MAX_LEN; i++)
      data_d[8*i +: 8] = upd ? (i < int'(len_d) ? cs_q[nxt[i]] : 8'h00) : data_q[8*i +: 8];
  end
  always_ff @(posedge clk)
    if (cs_we && state_q != RUN && int'(cs_addr) < MAX_CHARS) cs_q[cs_addr] <= cs_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      len_q <= '0;
      num_q <= '0;
      tgt_q <= '0;
      grow_q <= 1'b0;
      lo_q <= '0;
      hi_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      done_q <= done_d;
      err_q <= err_d;
      len_q <= len_d;
      num_q <= num_d;
      tgt_q <= tgt_d;
      grow_q <= grow_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
    end
  assign cand_valid = valid_q;
  assign cand_data = data_q;
  assign cand_len = len_q;
  assign busy = state_q == RUN;
  assign done = done_q;
  assign err = err_q;
  assign cand_cnt = cnt_q;
endmodule
